// File: rtl/irq_ctrl_if.sv
// Wishbone-style register bus between the cpu (master) and the interrupt controller (slave).
interface irq_ctrl_if;
  logic        stb_i;
  logic        we_i;
  logic [3:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack_o;

  modport master (output stb_i, we_i, adr_i, dat_i, input dat_o, ack_o);
  modport slave  (input stb_i, we_i, adr_i, dat_i, output dat_o, ack_o);
endinterface

// File: rtl/irq_ctrl.sv
// Parametrised vectored interrupt controller: per-line enable/mode/pending, fixed
// lowest-index priority, one registered request with vector address to the cpu.
module irq_ctrl #(
  parameter int unsigned N_IRQ       = 8,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0004,
  parameter int unsigned VEC_STRIDE  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [N_IRQ-1:0] irq_in,
  irq_ctrl_if.slave        bus,
  output logic             cpu_irq,
  output logic [31:0]      cpu_vec,
  input  logic             cpu_take,
  input  logic             cpu_rti,
  output logic [N_IRQ-1:0] irqack
);

  localparam int unsigned ID_W = 5;

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_cur_id, w_cur_id_nxt, w_prio_id;
  logic             r_cpu_irq, w_cpu_irq_nxt;
  logic [31:0]      r_cpu_vec;
  logic [N_IRQ-1:0] r_irqack, w_irqack_nxt, w_take_clr;
  logic [N_IRQ-1:0] r_enable, r_mode, r_pending, r_prev;
  logic [N_IRQ-1:0] w_s_irq, w_rise, w_w1c, w_pend_nxt, w_elig;
  logic             w_any, w_acc, w_wr;
  logic [1:0]       w_sel;
  logic             r_ack;
  logic [31:0]      r_dat, w_rd;
  logic             w_unused;

  // Input synchroniser chain
  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_s_irq = irq_in;
  end else begin : g_sync
    logic [N_IRQ-1:0] r_sync [SYNC_STAGES];
    always_ff @(posedge clk) begin
      if (rst_i) begin
        for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= '0;
      end else begin
        r_sync[0] <= irq_in;
        for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
      end
    end
    assign w_s_irq = r_sync[SYNC_STAGES-1];
  end

  assign w_acc    = bus.stb_i & ~r_ack;
  assign w_wr     = w_acc & bus.we_i;
  assign w_sel    = bus.adr_i[3:2];
  assign w_unused = ^{bus.adr_i[1:0], bus.dat_i};

  assign w_rise = w_s_irq & ~r_prev;
  assign w_w1c  = (w_wr && w_sel == 2'd1) ? bus.dat_i[N_IRQ-1:0] : '0;
  // Edge bits: a new edge beats W1C/take in the same cycle; level bits just follow the line.
  assign w_pend_nxt = (r_mode & ((r_pending & ~w_w1c & ~w_take_clr) | w_rise))
                    | (~r_mode & w_s_irq);
  assign w_elig = r_pending & r_enable;
  assign w_any  = |w_elig;

  always_comb begin
    w_prio_id = '0;
    for (int i = int'(N_IRQ) - 1; i >= 0; i--) begin
      if (w_elig[i]) w_prio_id = ID_W'(i);
    end
  end

  always_comb begin
    w_rd = '0;
    case (w_sel)
      2'd0: w_rd = 32'(r_enable);
      2'd1: w_rd = 32'(r_pending);
      2'd2: w_rd = 32'(r_mode);
      default: w_rd = {r_state == SERVICE, r_cpu_irq, 25'd0, r_cur_id};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_enable  <= '0;
      r_mode    <= '0;
      r_pending <= '0;
      r_prev    <= '0;
      r_ack     <= 1'b0;
      r_dat     <= '0;
    end else begin
      r_prev    <= w_s_irq;
      r_pending <= w_pend_nxt;
      r_ack     <= w_acc;
      r_dat     <= (w_acc && !bus.we_i) ? w_rd : '0;
      if (w_wr && w_sel == 2'd0) r_enable <= bus.dat_i[N_IRQ-1:0];
      if (w_wr && w_sel == 2'd2) r_mode   <= bus.dat_i[N_IRQ-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cur_id_nxt  = r_cur_id;
    w_cpu_irq_nxt = 1'b0;
    w_irqack_nxt  = '0;
    w_take_clr    = '0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_cur_id_nxt  = w_prio_id;
          w_cpu_irq_nxt = 1'b1;
          w_state_nxt   = REQ;
        end
      end
      REQ: begin
        if (cpu_take) begin
          w_irqack_nxt = N_IRQ'(1) << r_cur_id;
          w_take_clr   = N_IRQ'(1) << r_cur_id;
          w_state_nxt  = SERVICE;
        end else if (!w_any) begin
          w_state_nxt = IDLE;
        end else begin
          w_cur_id_nxt  = w_prio_id;
          w_cpu_irq_nxt = 1'b1;
        end
      end
      SERVICE: begin
        if (cpu_rti) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Registered cpu-side outputs; the vector follows cur_id every cycle.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_cur_id  <= '0;
      r_cpu_irq <= 1'b0;
      r_cpu_vec <= VEC_BASE;
      r_irqack  <= '0;
    end else begin
      r_cur_id  <= w_cur_id_nxt;
      r_cpu_irq <= w_cpu_irq_nxt;
      r_cpu_vec <= VEC_BASE + 32'(w_cur_id_nxt) * 32'(VEC_STRIDE);
      r_irqack  <= w_irqack_nxt;
    end
  end

  assign cpu_irq   = r_cpu_irq;
  assign cpu_vec   = r_cpu_vec;
  assign irqack    = r_irqack;
  assign bus.ack_o = r_ack;
  assign bus.dat_o = r_dat;

endmodule
